// File: rtl/mmt_seq_ctrl_if.sv
// Handshake and SRAM bus bundle of the MMT control sequencer.
// slave = sequencer side, master = datapath/stimulus side.
interface mmt_seq_ctrl_if #(
   parameter int AW = 13
);
   logic          in_valid;
   logic [7:0]    matrix;
   logic [1:0]    matrix_size;
   logic          in_valid2;
   logic [4:0]    matrix_idx;
   logic [1:0]    mode;
   logic          fetch_ready;
   logic          core_done;
   logic          sram_we;
   logic          sram_re;
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_wdata;
   logic          rd_tag_valid;
   logic [1:0]    rd_tag;
   logic [3:0]    rd_row;
   logic [3:0]    rd_col;
   logic [1:0]    cfg_size;
   logic          core_start;
   logic          busy;

   modport slave (
      input  in_valid, matrix, matrix_size,
      input  in_valid2, matrix_idx, mode,
      input  fetch_ready, core_done,
      output sram_we, sram_re, sram_addr, sram_wdata,
      output rd_tag_valid, rd_tag, rd_row, rd_col,
      output cfg_size, core_start, busy
   );

   modport master (
      output in_valid, matrix, matrix_size,
      output in_valid2, matrix_idx, mode,
      output fetch_ready, core_done,
      input  sram_we, sram_re, sram_addr, sram_wdata,
      input  rd_tag_valid, rd_tag, rd_row, rd_col,
      input  cfg_size, core_start, busy
   );
endinterface

// File: rtl/mmt_seq_ctrl.sv
// MMT control sequencer: loads 32 matrices into the operand SRAM,
// then serves ROUNDS operand-fetch / core-start requests per load.
module mmt_seq_ctrl #(
   parameter int ROUNDS = 10,
   parameter int AW     = 13
) (
   input  logic           clk,
   input  logic           rst_n,
   mmt_seq_ctrl_if.slave  bus
);
   localparam int RW = $clog2(ROUNDS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT2,
      S_GET_IDX,
      S_FETCH,
      S_KICK,
      S_WAIT_DONE
   } state_t;

   state_t        r_state, w_state;
   logic [4:0]    r_m, w_m;
   logic [3:0]    r_r, w_r;
   logic [3:0]    r_c, w_c;
   logic [1:0]    r_op, w_op;
   logic [4:0]    r_idx_a, w_idx_a;
   logic [4:0]    r_idx_b, w_idx_b;
   logic [4:0]    r_idx_c, w_idx_c;
   logic [1:0]    r_mode, w_mode;
   logic          r_icnt, w_icnt;
   logic [RW-1:0] r_round, w_round;

   logic          r_we, w_we;
   logic          r_re, w_re;
   logic [AW-1:0] r_addr, w_addr;
   logic [7:0]    r_wdata, w_wdata;
   logic [1:0]    r_iss_tag, w_iss_tag;
   logic [3:0]    r_iss_row, w_iss_row;
   logic [3:0]    r_iss_col, w_iss_col;
   logic          r_rvld;
   logic [1:0]    r_rtag;
   logic [3:0]    r_rrow;
   logic [3:0]    r_rcol;
   logic [1:0]    r_cfg, w_cfg;
   logic          r_start, w_start;
   logic          r_busy, w_busy;

   logic [1:0]    w_sz;
   logic [3:0]    w_nm1;
   logic          w_c_last;
   logic          w_r_last;
   logic          w_m_last;
   logic          w_ld;
   logic          w_fe;
   logic [4:0]    w_idx_cur;
   logic          w_tr;

   // The first load element arrives in IDLE, before cfg_size is latched.
   assign w_sz     = (r_state == S_IDLE) ? bus.matrix_size : r_cfg;
   assign w_nm1    = 4'((5'd2 << w_sz) - 5'd1);
   assign w_c_last = (r_c == w_nm1);
   assign w_r_last = (r_r == w_nm1);
   assign w_m_last = (r_m == 5'd31);
   assign w_tr     = (r_mode == r_op + 2'd1);

   always_comb begin
      w_idx_cur = r_idx_c;
      unique case (r_op)
         2'd0:    w_idx_cur = r_idx_a;
         2'd1:    w_idx_cur = r_idx_b;
         default: w_idx_cur = r_idx_c;
      endcase
   end

   always_comb begin
      w_state   = r_state;
      w_m       = r_m;
      w_r       = r_r;
      w_c       = r_c;
      w_op      = r_op;
      w_idx_a   = r_idx_a;
      w_idx_b   = r_idx_b;
      w_idx_c   = r_idx_c;
      w_mode    = r_mode;
      w_icnt    = r_icnt;
      w_round   = r_round;
      w_we      = 1'b0;
      w_re      = 1'b0;
      w_addr    = r_addr;
      w_wdata   = r_wdata;
      w_iss_tag = r_iss_tag;
      w_iss_row = r_iss_row;
      w_iss_col = r_iss_col;
      w_cfg     = r_cfg;
      w_ld      = 1'b0;
      w_fe      = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_cfg   = bus.matrix_size;
               w_state = S_LOAD;
               w_ld    = 1'b1;
            end
         end
         S_LOAD: begin
            if (bus.in_valid) begin
               w_ld = 1'b1;
               if (w_c_last && w_r_last && w_m_last)
                  w_state = S_WAIT2;
            end
         end
         S_WAIT2: begin
            if (bus.in_valid2) begin
               w_idx_a = bus.matrix_idx;
               w_mode  = bus.mode;
               w_icnt  = 1'b0;
               w_state = S_GET_IDX;
            end
         end
         S_GET_IDX: begin
            if (!r_icnt) begin
               w_idx_b = bus.matrix_idx;
               w_icnt  = 1'b1;
            end else begin
               w_idx_c = bus.matrix_idx;
               w_op    = 2'd0;
               w_r     = 4'd0;
               w_c     = 4'd0;
               w_state = S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.fetch_ready) begin
               w_fe = 1'b1;
               if (r_op == 2'd2 && w_r_last && w_c_last)
                  w_state = S_KICK;
            end
         end
         S_KICK: begin
            w_state = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (bus.core_done) begin
               if (r_round == RW'(ROUNDS - 1)) begin
                  w_round = '0;
                  w_state = S_IDLE;
               end else begin
                  w_round = r_round + 1'b1;
                  w_state = S_WAIT2;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase

      // Load walk: c, then r, then matrix; all wrap back to 0 at the end.
      if (w_ld) begin
         w_we    = 1'b1;
         w_addr  = {r_m, r_r, r_c};
         w_wdata = bus.matrix;
         if (w_c_last) begin
            w_c = 4'd0;
            if (w_r_last) begin
               w_r = 4'd0;
               w_m = r_m + 5'd1;
            end else begin
               w_r = r_r + 4'd1;
            end
         end else begin
            w_c = r_c + 4'd1;
         end
      end

      // Fetch walk: logical r-major order, physical swap when transposed.
      if (w_fe) begin
         w_re      = 1'b1;
         w_addr    = w_tr ? {w_idx_cur, r_c, r_r}
                          : {w_idx_cur, r_r, r_c};
         w_iss_tag = r_op;
         w_iss_row = r_r;
         w_iss_col = r_c;
         if (w_c_last) begin
            w_c = 4'd0;
            if (w_r_last) begin
               w_r  = 4'd0;
               w_op = (r_op == 2'd2) ? 2'd0 : r_op + 2'd1;
            end else begin
               w_r = r_r + 4'd1;
            end
         end else begin
            w_c = r_c + 4'd1;
         end
      end

      w_start = (w_state == S_KICK);
      w_busy  = (w_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_m       <= '0;
         r_r       <= '0;
         r_c       <= '0;
         r_op      <= '0;
         r_idx_a   <= '0;
         r_idx_b   <= '0;
         r_idx_c   <= '0;
         r_mode    <= '0;
         r_icnt    <= 1'b0;
         r_round   <= '0;
         r_we      <= 1'b0;
         r_re      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_iss_tag <= '0;
         r_iss_row <= '0;
         r_iss_col <= '0;
         r_rvld    <= 1'b0;
         r_rtag    <= '0;
         r_rrow    <= '0;
         r_rcol    <= '0;
         r_cfg     <= '0;
         r_start   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_m       <= w_m;
         r_r       <= w_r;
         r_c       <= w_c;
         r_op      <= w_op;
         r_idx_a   <= w_idx_a;
         r_idx_b   <= w_idx_b;
         r_idx_c   <= w_idx_c;
         r_mode    <= w_mode;
         r_icnt    <= w_icnt;
         r_round   <= w_round;
         r_we      <= w_we;
         r_re      <= w_re;
         r_addr    <= w_addr;
         r_wdata   <= w_wdata;
         r_iss_tag <= w_iss_tag;
         r_iss_row <= w_iss_row;
         r_iss_col <= w_iss_col;
         r_rvld    <= r_re;
         r_rtag    <= r_iss_tag;
         r_rrow    <= r_iss_row;
         r_rcol    <= r_iss_col;
         r_cfg     <= w_cfg;
         r_start   <= w_start;
         r_busy    <= w_busy;
      end
   end

   assign bus.sram_we      = r_we;
   assign bus.sram_re      = r_re;
   assign bus.sram_addr    = r_addr;
   assign bus.sram_wdata   = r_wdata;
   assign bus.rd_tag_valid = r_rvld;
   assign bus.rd_tag       = r_rtag;
   assign bus.rd_row       = r_rrow;
   assign bus.rd_col       = r_rcol;
   assign bus.cfg_size     = r_cfg;
   assign bus.core_start   = r_start;
   assign bus.busy         = r_busy;
endmodule

// File: doc/mmt_seq_ctrl.md
Name: mmt_seq_ctrl

Overview:
- Control sequencer for the MMT matrix-multiply datapath.
- Load phase: streams the 32 incoming matrices into the operand SRAM using a fixed address map.
- Compute phase: for each request it captures three matrix indices plus a mode, issues transposition-aware operand reads to the SRAM and tags each read for the systolic array.
- It then starts the core and waits for the core to finish before accepting the next request.

Parameters:
- ROUNDS, 10, compute requests (in_valid2 bursts) served per load before returning to IDLE.
- AW, 13, SRAM address width (5-bit matrix index, 4-bit row, 4-bit column).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  load-phase element strobe
- matrix  in  8  matrix element, row-major within each matrix, matrices 0..31 in order
- matrix_size  in  2  sampled on the first in_valid cycle only; N = 2,4,8,16 for 0..3
- in_valid2  in  1  index strobe, high exactly 3 consecutive cycles per request
- matrix_idx  in  5  index of A, B, C on in_valid2 cycles 1, 2, 3
- mode  in  2  sampled on in_valid2 cycle 1 only
- fetch_ready  in  1  datapath can accept a read this cycle
- core_done  in  1  one-cycle pulse from the datapath: result complete
- sram_we  out  1  write strobe
- sram_re  out  1  read strobe
- sram_addr  out  AW  SRAM address
- sram_wdata  out  8  write data
- rd_tag_valid  out  1  SRAM read data valid this cycle (sram_re delayed 1 cycle)
- rd_tag  out  2  operand of the returning data: 0=A, 1=B, 2=C
- rd_row  out  4  logical row of the returning element
- rd_col  out  4  logical column of the returning element
- cfg_size  out  2  latched matrix_size
- core_start  out  1  one-cycle start pulse to the datapath
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE. Reset mid-operation aborts immediately; SRAM contents are untouched.
- Outputs are registered.
- Address map: addr = {mat[4:0], r[3:0], c[3:0]}. The matrix stride is 256 regardless of N.

States:
- IDLE -> LOAD on in_valid; matrix_size is latched into cfg_size on that same cycle.
- LOAD:
  - Each in_valid cycle produces sram_we=1 one cycle later, with sram_wdata = matrix and addr = {m,r,c}.
  - c increments; wrap at N-1 increments r; r wrap increments m.
  - After the 32*N*N-th element, go to WAIT2.
  - An in_valid gap holds the counters and keeps sram_we at 0.
- WAIT2 -> GET_IDX on in_valid2. Capture idxA and mode, then idxB, then idxC on the following cycles.
- GET_IDX -> FETCH after the 3rd cycle.
- FETCH:
  - Operands are fetched in order A, B, C. Each operand reads N*N elements, logical order r-major then c.
  - A read is issued (sram_re=1) only in cycles where fetch_ready=1. Otherwise the address and counters hold and sram_re=0.
  - Physical address is {idx,r,c}, or {idx,c,r} when the operand is transposed.
  - Transposition by mode: 0 none, 1 A, 2 B, 3 C.
  - rd_tag_valid, rd_tag, rd_row and rd_col are the issue-cycle values delayed 1 cycle. rd_row/rd_col carry logical indices.
  - After the last C read is issued -> KICK.
- KICK: core_start=1 for one cycle -> WAIT_DONE.
- WAIT_DONE: on core_done, increment the round count.
  - If the count equals ROUNDS -> IDLE, with the round count cleared.
  - Otherwise -> WAIT2.

Ignored inputs:
- core_done outside WAIT_DONE.
- in_valid2 outside WAIT2.
- in_valid outside IDLE/LOAD.
- sram_we and sram_re are never both 1.

Test Plan:
- Reset value check: assert rst_n=0 during LOAD -> next cycle all outputs 0 and busy=0. A fresh load then restarts at addr 0.
- Load 2x2 (matrix_size=0, 128 elements, values k mod 256) -> 128 writes.
  - Element 5 goes to addr {1,0,1}=0x101.
  - Last element goes to 0x1F11 (matrix 31, row 1, col 1).
  - State reaches WAIT2.
- Request, N=4, mode=0, idx 3,7,9 -> 48 reads.
  - First addr 0x300.
  - A element (1,2) at 0x312.
  - B reads start at 0x700.
  - rd_tag sequence: 16×0, 16×1, 16×2.
  - Then one core_start pulse.
- Request, N=4, mode=2, idx 0,1,2 -> B element (1,2) read at 0x121, with rd_row=1 and rd_col=2. A and C are not transposed.
- fetch_ready toggled 1,0,0,1 during FETCH -> sram_re mirrors it; sram_addr holds across the two stall cycles; no element is skipped or duplicated.
- 10 requests each completed by core_done -> IDLE and busy=0 after the 10th. A core_done sent during FETCH in between is ignored, and the round count is unchanged.
